// File: rtl/his_peak_finder.sv
// Histogram peak finder: scans every bin of every pixel through SRAM port b and
// reports the first-occurring maximum bin per pixel, then pulses done.
//
// state  | meaning
// IDLE   | read port off, waiting for start
// READ   | issuing one bin address per cycle for the current pixel
// DRAIN  | port off, last bin's read data compared
// REPORT | peak fields strobed for the current pixel
// DONE   | done strobe, last busy cycle
module his_peak_finder #(
  parameter int BIN_NUM   = 16,
  parameter int PIXEL_NUM = 4,
  parameter int ADDR_W    = 6,
  parameter int CNT_W     = 8,
  parameter int BIN_W     = 4,
  parameter int PIX_W     = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1
) (
  input  logic              i_clk,
  input  logic              i_res,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_counts,
  output logic [ADDR_W-1:0] o_raddr,
  output logic              o_r_enable,
  output logic              o_read_flag,
  output logic              o_busy,
  output logic              o_peak_valid,
  output logic [PIX_W-1:0]  o_peak_pixel,
  output logic [BIN_W-1:0]  o_peak_bin,
  output logic [CNT_W-1:0]  o_peak_count,
  output logic              o_peak_hit,
  output logic              o_done
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_REPORT, S_DONE} state_t;

  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(BIN_NUM - 1);
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(PIXEL_NUM - 1);

  state_t r_state, w_state_nxt;

  logic [PIX_W-1:0]  r_pixel, w_pixel_nxt;
  logic [BIN_W-1:0]  r_bin, w_bin_nxt;
  logic [ADDR_W-1:0] r_raddr, w_raddr_nxt;
  logic              r_r_enable, w_r_enable_nxt;
  logic              r_read_flag, w_read_flag_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_tag, w_tag_nxt;
  logic [BIN_W-1:0]  r_tag_bin, w_tag_bin_nxt;
  logic [CNT_W-1:0]  r_max, w_max_nxt;
  logic [BIN_W-1:0]  r_idx, w_idx_nxt;
  logic              r_peak_valid, w_peak_valid_nxt;
  logic [PIX_W-1:0]  r_peak_pixel, w_peak_pixel_nxt;
  logic [BIN_W-1:0]  r_peak_bin, w_peak_bin_nxt;
  logic [CNT_W-1:0]  r_peak_count, w_peak_count_nxt;
  logic              r_peak_hit, w_peak_hit_nxt;
  logic              r_done, w_done_nxt;

  logic              w_upd;
  logic [CNT_W-1:0]  w_max;
  logic [BIN_W-1:0]  w_idx;

  // Strict compare keeps the earliest bin on ties.
  assign w_upd = r_tag && (i_counts > r_max);
  assign w_max = w_upd ? i_counts  : r_max;
  assign w_idx = w_upd ? r_tag_bin : r_idx;

  always_ff @(posedge i_clk) begin
    if (!i_res) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pixel_nxt      = r_pixel;
    w_bin_nxt        = r_bin;
    w_raddr_nxt      = r_raddr;
    w_r_enable_nxt   = r_r_enable;
    w_read_flag_nxt  = r_read_flag;
    w_busy_nxt       = r_busy;
    w_tag_nxt        = 1'b0;
    w_tag_bin_nxt    = r_tag_bin;
    w_max_nxt        = w_max;
    w_idx_nxt        = w_idx;
    w_peak_valid_nxt = 1'b0;
    w_peak_pixel_nxt = r_peak_pixel;
    w_peak_bin_nxt   = r_peak_bin;
    w_peak_count_nxt = r_peak_count;
    w_peak_hit_nxt   = r_peak_hit;
    w_done_nxt       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt     = S_READ;
          w_pixel_nxt     = '0;
          w_bin_nxt       = '0;
          w_raddr_nxt     = '0;
          w_r_enable_nxt  = 1'b0;
          w_read_flag_nxt = 1'b1;
          w_busy_nxt      = 1'b1;
          w_max_nxt       = '0;
          w_idx_nxt       = '0;
        end
      end
      S_READ: begin
        w_tag_nxt     = 1'b1;
        w_tag_bin_nxt = r_bin;
        if (r_bin == LAST_BIN) begin
          w_state_nxt     = S_DRAIN;
          w_r_enable_nxt  = 1'b1;
          w_read_flag_nxt = 1'b0;
        end else begin
          w_bin_nxt   = r_bin + BIN_W'(1);
          w_raddr_nxt = r_raddr + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        w_state_nxt      = S_REPORT;
        w_peak_valid_nxt = 1'b1;
        w_peak_pixel_nxt = r_pixel;
        w_peak_bin_nxt   = w_idx;
        w_peak_count_nxt = w_max;
        w_peak_hit_nxt   = (w_max != '0);
        w_max_nxt        = '0;
        w_idx_nxt        = '0;
      end
      S_REPORT: begin
        if (r_pixel != LAST_PIX) begin
          // Pixels are contiguous in the SRAM, so the address simply continues.
          w_state_nxt     = S_READ;
          w_pixel_nxt     = r_pixel + PIX_W'(1);
          w_bin_nxt       = '0;
          w_raddr_nxt     = r_raddr + ADDR_W'(1);
          w_r_enable_nxt  = 1'b0;
          w_read_flag_nxt = 1'b1;
        end else begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_res) begin
      r_pixel      <= '0;
      r_bin        <= '0;
      r_raddr      <= '0;
      r_r_enable   <= 1'b1;
      r_read_flag  <= 1'b0;
      r_busy       <= 1'b0;
      r_tag        <= 1'b0;
      r_tag_bin    <= '0;
      r_max        <= '0;
      r_idx        <= '0;
      r_peak_valid <= 1'b0;
      r_peak_pixel <= '0;
      r_peak_bin   <= '0;
      r_peak_count <= '0;
      r_peak_hit   <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_pixel      <= w_pixel_nxt;
      r_bin        <= w_bin_nxt;
      r_raddr      <= w_raddr_nxt;
      r_r_enable   <= w_r_enable_nxt;
      r_read_flag  <= w_read_flag_nxt;
      r_busy       <= w_busy_nxt;
      r_tag        <= w_tag_nxt;
      r_tag_bin    <= w_tag_bin_nxt;
      r_max        <= w_max_nxt;
      r_idx        <= w_idx_nxt;
      r_peak_valid <= w_peak_valid_nxt;
      r_peak_pixel <= w_peak_pixel_nxt;
      r_peak_bin   <= w_peak_bin_nxt;
      r_peak_count <= w_peak_count_nxt;
      r_peak_hit   <= w_peak_hit_nxt;
      r_done       <= w_done_nxt;
    end
  end

  assign o_raddr      = r_raddr;
  assign o_r_enable   = r_r_enable;
  assign o_read_flag  = r_read_flag;
  assign o_busy       = r_busy;
  assign o_peak_valid = r_peak_valid;
  assign o_peak_pixel = r_peak_pixel;
  assign o_peak_bin   = r_peak_bin;
  assign o_peak_count = r_peak_count;
  assign o_peak_hit   = r_peak_hit;
  assign o_done       = r_done;

endmodule

// File: tb/tb_his_peak_finder.sv
// Bench for his_peak_finder: SRAM model plus a per-pixel argmax reference,
// checked cycle by cycle over directed and randomized frames.
module tb_his_peak_finder;
  localparam int BIN_NUM   = 16;
  localparam int PIXEL_NUM = 4;
  localparam int NWORDS    = BIN_NUM * PIXEL_NUM;
  localparam int FRAME     = BIN_NUM + 2;
  localparam int DONE_CYC  = PIXEL_NUM * FRAME + 1;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       start = 1'b0;
  logic [7:0] counts = 8'd0;
  logic [5:0] raddr;
  logic       r_enable, read_flag, busy, peak_valid, peak_hit, done;
  logic [1:0] peak_pixel;
  logic [3:0] peak_bin;
  logic [7:0] peak_count;

  logic [7:0] mem [NWORDS];
  int exp_bin [PIXEL_NUM];
  int exp_cnt [PIXEL_NUM];
  int last_pix, last_bin, last_cnt, last_hit;
  int n_vec = 0;
  int n_err = 0;

  his_peak_finder dut (
    .i_clk(clk), .i_res(res), .i_start(start), .i_counts(counts),
    .o_raddr(raddr), .o_r_enable(r_enable), .o_read_flag(read_flag), .o_busy(busy),
    .o_peak_valid(peak_valid), .o_peak_pixel(peak_pixel), .o_peak_bin(peak_bin),
    .o_peak_count(peak_count), .o_peak_hit(peak_hit), .o_done(done)
  );

  always #5 clk = ~clk;

  // SRAM port b: data one cycle after an enabled read, junk otherwise.
  always @(posedge clk) begin
    if (!r_enable && read_flag) counts <= mem[raddr];
    else                        counts <= 8'($urandom);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build_model();
    for (int p = 0; p < PIXEL_NUM; p++) begin
      int best, at;
      best = 0; at = 0;
      for (int b = 0; b < BIN_NUM; b++)
        if (int'(mem[p*BIN_NUM+b]) > best) begin best = int'(mem[p*BIN_NUM+b]); at = b; end
      exp_bin[p] = at;
      exp_cnt[p] = best;
    end
  endtask

  task automatic fill_random(input int hi);
    for (int i = 0; i < NWORDS; i++) mem[i] = 8'($urandom_range(hi, 0));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_raddr"}, raddr, 0);
    chk({tag, "_ren"}, r_enable, 1);
    chk({tag, "_rflag"}, read_flag, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_pvalid"}, peak_valid, 0);
    chk({tag, "_ppix"}, peak_pixel, 0);
    chk({tag, "_pbin"}, peak_bin, 0);
    chk({tag, "_pcnt"}, peak_count, 0);
    chk({tag, "_phit"}, peak_hit, 0);
    chk({tag, "_done"}, done, 0);
    last_pix = 0; last_bin = 0; last_cnt = 0; last_hit = 0;
  endtask

  // Entered and left at a falling edge; start goes high in the entry cycle (cycle 0).
  task automatic run_frame(input int abort_at, input bit extra_starts);
    int p, off;
    bit rd, pv;
    start = 1'b1;
    for (int c = 1; c <= DONE_CYC + 1; c++) begin
      @(negedge clk);
      start = extra_starts && (c == 5 || c == 40);
      p   = (c - 1) / FRAME;
      off = (c - 1) % FRAME;
      rd  = (c < DONE_CYC) && (off < BIN_NUM);
      pv  = (c < DONE_CYC) && (off == FRAME - 1);
      chk("busy", busy, (c <= DONE_CYC) ? 1 : 0);
      chk("done", done, (c == DONE_CYC) ? 1 : 0);
      chk("r_enable", r_enable, rd ? 0 : 1);
      chk("read_flag", read_flag, rd ? 1 : 0);
      if (rd) chk("raddr", raddr, p * BIN_NUM + off);
      chk("peak_valid", peak_valid, pv ? 1 : 0);
      if (pv) begin
        last_pix = p;
        last_bin = exp_bin[p];
        last_cnt = exp_cnt[p];
        last_hit = (exp_cnt[p] != 0) ? 1 : 0;
      end
      chk("peak_pixel", peak_pixel, last_pix);
      chk("peak_bin", peak_bin, last_bin);
      chk("peak_count", peak_count, last_cnt);
      chk("peak_hit", peak_hit, last_hit);
      if (c == abort_at) begin
        res = 1'b0;
        @(negedge clk);
        chk_reset_vals("abort");
        @(negedge clk);
        res = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("post_abort_done", done, 0);
          chk("post_abort_busy", busy, 0);
        end
        return;
      end
    end
  endtask

  initial begin
    res = 1'b0;
    start = 1'b0;
    for (int i = 0; i < NWORDS; i++) mem[i] = 8'd0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    res = 1'b1;
    repeat (2) @(negedge clk);

    // Ramp on pixel 0, all-zero pixels elsewhere.
    for (int i = 0; i < NWORDS; i++) mem[i] = 8'd0;
    for (int b = 0; b < BIN_NUM; b++) mem[b] = 8'(b);
    build_model();
    run_frame(0, 1'b0);

    // Tie on pixel 2: earliest bin must win.
    fill_random(255);
    for (int b = 0; b < BIN_NUM; b++) mem[2*BIN_NUM+b] = 8'd10;
    mem[2*BIN_NUM+3] = 8'd200;
    mem[2*BIN_NUM+9] = 8'd200;
    build_model();
    run_frame(0, 1'b0);

    // Full-scale count at bin 0 against a near-full last bin; ties elsewhere.
    fill_random(7);
    for (int b = 0; b < BIN_NUM; b++) mem[BIN_NUM+b] = 8'($urandom_range(253, 0));
    mem[BIN_NUM]     = 8'd255;
    mem[2*BIN_NUM-1] = 8'd254;
    build_model();
    run_frame(0, 1'b0);

    // Reset mid-scan, then a clean frame.
    fill_random(255);
    build_model();
    run_frame(30, 1'b0);
    fill_random(255);
    build_model();
    run_frame(0, 1'b0);

    // Stray starts mid-scan, then a back-to-back frame.
    fill_random(255);
    build_model();
    run_frame(0, 1'b1);
    fill_random(31);
    build_model();
    run_frame(0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
